// File: rtl/jam_enum_param.sv
// Exhaustive N-worker / N-job assignment engine: walks all N! permutations in
// lexicographic order, sums table costs and keeps the best (min or max) total.
module jam_enum_param #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int MC_W   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   mode_max,
    output logic                   busy,
    output logic [IDX_W-1:0]       W,
    output logic [IDX_W-1:0]       J,
    input  logic [COST_W-1:0]      Cost,
    output logic [MC_W-1:0]        MatchCount,
    output logic [SUM_W-1:0]       BestCost,
    output logic [N*IDX_W-1:0]     BestPerm,
    output logic                   Valid
);

    typedef enum logic [1:0] {IDLE, EVAL, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [SUM_W-1:0] acc_q;
    logic             mode_q;
    logic             first_q;
    logic [IDX_W-1:0] perm_q   [N];
    logic [IDX_W-1:0] perm_nxt [N];
    logic [IDX_W-1:0] swapped  [N];
    logic [IDX_W-1:0] piv, swp;
    logic             found;
    logic             last_perm;
    logic             better;

    // Successor permutation (standard next-lexicographic step).
    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        found = 1'b0;
        piv   = '0;
        swp   = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm_q[i] < perm_q[i+1]) begin
                found = 1'b1;
                piv   = IDX_W'(i);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (IDX_W'(j) > piv && perm_q[j] > perm_q[piv]) swp = IDX_W'(j);
        end
        swapped      = perm_q;
        swapped[piv] = perm_q[swp];
        swapped[swp] = perm_q[piv];
        perm_nxt     = swapped;
        for (int k = 0; k < N; k++) begin
            if (IDX_W'(k) > piv) perm_nxt[k] = swapped[N + int'(piv) - k];
        end
        // Descending order has no pivot: wrap back to identity.
        if (!found) begin
            for (int k = 0; k < N; k++) perm_nxt[k] = IDX_W'(k);
        end
        last_perm = !found;
    end

    assign better = mode_q ? (acc_q > BestCost) : (acc_q < BestCost);

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        Valid   = (state_q == DONE);
        W       = '0;
        J       = '0;
        case (state_q)
            IDLE: if (start) state_d = EVAL;
            EVAL: begin
                W = cnt_q;
                J = perm_q[cnt_q];
                if (cnt_q == IDX_W'(N - 1)) state_d = CMP;
            end
            CMP:  state_d = last_perm ? DONE : EVAL;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            first_q    <= 1'b0;
            BestCost   <= '0;
            MatchCount <= '0;
            BestPerm   <= '0;
            // NOTE: the permutation array is a handful of flops, not a RAM, so
            // it is reset explicitly to identity like any other register.
            for (int k = 0; k < N; k++) perm_q[k] <= IDX_W'(k);
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode_max;
                        first_q <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                EVAL: begin
                    acc_q <= acc_q + SUM_W'(Cost);
                    cnt_q <= (cnt_q == IDX_W'(N - 1)) ? '0 : cnt_q + 1'b1;
                end
                CMP: begin
                    if (first_q || better) begin
                        BestCost   <= acc_q;
                        MatchCount <= MC_W'(1);
                        for (int k = 0; k < N; k++) BestPerm[k*IDX_W +: IDX_W] <= perm_q[k];
                    end else if (acc_q == BestCost) begin
                        // Ties keep the earlier (lexicographically first) permutation.
                        MatchCount <= MatchCount + 1'b1;
                    end
                    first_q <= 1'b0;
                    acc_q   <= '0;
                    perm_q  <= perm_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_enum_param.sv
// Scoreboard bench for jam_enum_param: N=3 and N=4 instances against
// hand-computed per-cycle expectations popped by independent monitors.
module tb_jam_enum_param;

    typedef struct {
        int cyc;
        int w;
        int j;
        bit busy;
        bit valid;
        bit chk;
        int cost;
        int mc;
        int perm;
    } exp_t;

    logic       CLK, RST;
    logic       start3, mode3, busy3, Valid3;
    logic [1:0] W3, J3;
    logic [3:0] Cost3, MC3;
    logic [5:0] BC3, BP3;
    logic       start4, mode4, busy4, Valid4;
    logic [1:0] W4, J4;
    logic [2:0] Cost4;
    logic [4:0] MC4, BC4;
    logic [7:0] BP4;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q3[$];
    exp_t q4[$];
    exp_t e3, e4;
    int   p3 [6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};

    jam_enum_param #(.N(3), .IDX_W(2), .COST_W(4), .SUM_W(6), .MC_W(4)) dut3 (
        .CLK(CLK), .RST(RST), .start(start3), .mode_max(mode3), .busy(busy3),
        .W(W3), .J(J3), .Cost(Cost3), .MatchCount(MC3), .BestCost(BC3),
        .BestPerm(BP3), .Valid(Valid3)
    );

    jam_enum_param #(.N(4), .IDX_W(2), .COST_W(3), .SUM_W(5), .MC_W(5)) dut4 (
        .CLK(CLK), .RST(RST), .start(start4), .mode_max(mode4), .busy(busy4),
        .W(W4), .J(J4), .Cost(Cost4), .MatchCount(MC4), .BestCost(BC4),
        .BestPerm(BP4), .Valid(Valid4)
    );

    // Cost tables: diagonal-cheap for N=3, w+j for N=4.
    assign Cost3 = (W3 == J3) ? 4'd1 : 4'd10;
    assign Cost4 = {1'b0, W4} + {1'b0, J4};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int dut, input int c, input int w, input int j,
                                 input bit b, input bit v, input bit chk,
                                 input int cost, input int mc, input int perm);
        exp_t e;
        e.cyc = c; e.w = w; e.j = j; e.busy = b; e.valid = v;
        e.chk = chk; e.cost = cost; e.mc = mc; e.perm = perm;
        if (dut == 3) q3.push_back(e);
        else          q4.push_back(e);
    endfunction

    always @(negedge CLK) begin
        if (q3.size() != 0 && q3[0].cyc == cyc) begin
            e3 = q3.pop_front();
            check("trace3", 64'({W3, J3, busy3, Valid3}),
                  64'({e3.w[1:0], e3.j[1:0], e3.busy, e3.valid}));
            if (e3.chk) begin
                check("cost3", 64'(BC3), 64'(e3.cost));
                check("count3", 64'(MC3), 64'(e3.mc));
                check("perm3", 64'(BP3), 64'(e3.perm));
            end
        end else if (Valid3 !== 1'b0) begin
            check("spurious_valid3", 64'(Valid3), 64'(0));
        end
    end

    always @(negedge CLK) begin
        if (q4.size() != 0 && q4[0].cyc == cyc) begin
            e4 = q4.pop_front();
            check("trace4", 64'({W4, J4, busy4, Valid4}),
                  64'({e4.w[1:0], e4.j[1:0], e4.busy, e4.valid}));
            if (e4.chk) begin
                check("cost4", 64'(BC4), 64'(e4.cost));
                check("count4", 64'(MC4), 64'(e4.mc));
                check("perm4", 64'(BP4), 64'(e4.perm));
            end
        end else if (Valid4 !== 1'b0) begin
            check("spurious_valid4", 64'(Valid4), 64'(0));
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((q3.size() + q4.size()) != 0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check("drain", 64'(q3.size() + q4.size()), 64'(0));
        q3.delete();
        q4.delete();
    endtask

    initial begin
        int t0, k, ph;
        bit ev;
        RST = 1'b0; start3 = 1'b0; start4 = 1'b0; mode3 = 1'b0; mode4 = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        push(3, cyc + 1, 0, 0, 0, 0, 1, 0, 0, 0);
        push(4, cyc + 1, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // N=3 min run with full address trace and an ignored start at cycle 5.
        t0 = cyc; start3 = 1'b1; mode3 = 1'b0;
        for (int m = 1; m <= 26; m++) begin
            k  = (m - 1) / 4;
            ph = (m - 1) % 4;
            ev = (m <= 24) && (ph < 3);
            push(3, t0 + m, ev ? ph : 0, ev ? p3[k][ph] : 0, m <= 25, m == 25,
                 m >= 4, (m >= 5) ? 3 : 0, (m >= 5) ? 1 : 0, (m >= 5) ? 'h24 : 0);
        end
        @(negedge CLK);
        start3 = 1'b0;
        wait_cyc(t0 + 5);
        start3 = 1'b1;
        @(negedge CLK);
        start3 = 1'b0;
        drain(100);

        // Results hold through idle cycles.
        t0 = cyc;
        for (int m = 1; m <= 20; m++) push(3, t0 + m, 0, 0, 0, 0, 1, 3, 1, 'h24);
        drain(100);

        // Reset in the middle of a run clears everything on the next cycle.
        t0 = cyc; start3 = 1'b1; mode3 = 1'b1;
        push(3, t0 + 11, 0, 0, 0, 0, 1, 0, 0, 0);
        push(3, t0 + 12, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge CLK);
        start3 = 1'b0;
        wait_cyc(t0 + 10);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        drain(50);

        // Fresh min run: results stay zero until the first CMP lands.
        t0 = cyc; start3 = 1'b1; mode3 = 1'b0;
        push(3, t0 + 4,  0, 0, 1, 0, 1, 0, 0, 0);
        push(3, t0 + 5,  0, 0, 1, 0, 1, 3, 1, 'h24);
        push(3, t0 + 25, 0, 0, 1, 1, 1, 3, 1, 'h24);
        @(negedge CLK);
        start3 = 1'b0;
        drain(100);

        // Max run; mode_max dropped mid-run must not matter.
        t0 = cyc; start3 = 1'b1; mode3 = 1'b1;
        push(3, t0 + 3,  2, 2, 1, 0, 1, 3, 1, 'h24);
        push(3, t0 + 9,  0, 1, 1, 0, 1, 21, 1, 'h18);
        push(3, t0 + 25, 0, 0, 1, 1, 1, 30, 2, 'h09);
        for (int m = 26; m <= 45; m++) push(3, t0 + m, 0, 0, 0, 0, 1, 30, 2, 'h09);
        @(negedge CLK);
        start3 = 1'b0;
        wait_cyc(t0 + 7);
        mode3 = 1'b0;
        drain(100);

        // N=4, all sums equal; start held high launches a second run after DONE.
        t0 = cyc; start4 = 1'b1; mode4 = 1'b0;
        push(4, t0 + 5,   0, 0, 1, 0, 1, 0, 0, 0);
        push(4, t0 + 6,   0, 0, 1, 0, 1, 12, 1, 'hE4);
        push(4, t0 + 121, 0, 0, 1, 1, 1, 12, 24, 'hE4);
        push(4, t0 + 122, 0, 0, 0, 0, 1, 12, 24, 'hE4);
        push(4, t0 + 123, 0, 0, 1, 0, 1, 12, 24, 'hE4);
        push(4, t0 + 243, 0, 0, 1, 1, 1, 12, 24, 'hE4);
        push(4, t0 + 244, 0, 0, 0, 0, 1, 12, 24, 'hE4);
        wait_cyc(t0 + 100);
        mode4 = 1'b1;
        wait_cyc(t0 + 130);
        start4 = 1'b0;
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jam_enum_param.md
Name: jam_enum_param

Overview:
- Parametrised exhaustive job-assignment engine: N workers, N jobs.
- Enumerates all N! worker→job permutations in lexicographic order and reads each cost from an external combinational cost table via W/J.
- Reports the best total cost (min or max mode), the number of permutations that achieve it, and the first permutation reaching it.
- Successor to the fixed 8×8 min-cost block; adds N/width parameters, a start/busy handshake, max mode and a best-permutation output.

Parameters:
- N, 8, workers = jobs; legal 2..8.
- IDX_W, 3, width of W/J; 2^IDX_W >= N.
- COST_W, 7, width of one Cost entry.
- SUM_W, 10, accumulator and BestCost width; must satisfy N*(2^COST_W-1) < 2^SUM_W.
- MC_W, 16, MatchCount width; must satisfy 2^MC_W > N!.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-low reset; 0 = reset, sampled on CLK.
- start  in  1  run request; sampled only in IDLE.
- mode_max  in  1  0 = minimise, 1 = maximise; latched when start is accepted.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle.
- W  out  IDX_W  worker address to the cost table.
- J  out  IDX_W  job address to the cost table.
- Cost  in  COST_W  table data for (W,J); combinational, valid in the same cycle.
- MatchCount  out  MC_W  number of permutations equal to the best cost.
- BestCost  out  SUM_W  best total cost.
- BestPerm  out  N*IDX_W  job for worker w in bits [w*IDX_W +: IDX_W].
- Valid  out  1  one-cycle result strobe.

Behaviour:
- Reset (RST=0 at an edge), including mid-run: state→IDLE; busy=0, Valid=0, BestCost=0, MatchCount=0, BestPerm=0, accumulator=0, counter=0, permutation register=identity. Takes effect on the same edge.
- States and transitions:
  - IDLE → EVAL when start=1.
  - EVAL lasts exactly N cycles. Counter c runs 0..N-1. W=c, J=perm[c]. Each edge adds the zero-extended Cost to the accumulator (the accumulator starts at 0 for each permutation).
  - CMP lasts 1 cycle; compares the accumulated sum, then steps the permutation. Goes to DONE if the permutation is the descending order N-1..0, else back to EVAL.
  - DONE lasts 1 cycle; Valid=1, then → IDLE.
- Outside EVAL: W=0 and J=0; Cost is ignored.
- Compare rule in CMP:
  - First permutation of a run: BestCost=sum, MatchCount=1, BestPerm=perm, unconditionally.
  - Later permutations, if sum is strictly better (< in min mode, > in max mode): BestCost=sum, MatchCount=1, BestPerm=perm.
  - If sum equals BestCost: MatchCount+1, BestPerm unchanged, so the lexicographically first permutation is kept.
  - Otherwise no change.
- Next permutation is computed combinationally in CMP:
  - Find the largest i with p[i]<p[i+1].
  - Find the largest j>i with p[j]>p[i].
  - Swap p[i] and p[j], then reverse p[i+1..N-1].
  - After descending order the register reloads identity.
- Timing, with the start-accept edge as cycle 0:
  - Permutation k is in EVAL during cycles k(N+1)+1 .. k(N+1)+N and in CMP at (k+1)(N+1).
  - Valid is high during cycle N!(N+1)+1.
  - For N=8 that is cycle 362881; for N=3, cycle 25.
- Results hold after DONE until the next accepted start. Accepting a start clears them at the first CMP of the new run (first-permutation rule), not at start.
- start while busy is ignored. start held high in IDLE after DONE begins a new run.
- mode_max changes mid-run have no effect.
- No arithmetic overflow is possible under the parameter constraints; no saturation logic is required.

Test Plan:
- N=8, Cost constant 5, min mode → Valid pulses exactly once at cycle 362881; BestCost=40, MatchCount=40320, BestPerm=identity {0..7}.
- N=3, Cost(w,j)=(w==j)?1:10, min mode → BestCost=3, MatchCount=1, BestPerm={0,1,2}. Rerun with max mode → BestCost=30, MatchCount=2, BestPerm={1,2,0}.
- N=3 address trace → six EVAL bursts, W=0,1,2 in each. J sequence: 012, 021, 102, 120, 201, 210. W=J=0 in CMP/DONE/IDLE; Valid at cycle 25.
- N=4, Cost(w,j)=w+j → every sum is 12; BestCost=12, MatchCount=24, BestPerm={0,1,2,3}.
- Handshake, N=3: start pulsed again at cycle 5 → ignored, Valid still at cycle 25. RST=0 at cycle 10 → next cycle all outputs zero, busy=0. A fresh start then gives the same results as the clean run.
- Hold check: after Valid, outputs stay stable for 20 idle cycles with start=0; Valid stays 0 and busy stays 0.
